// File: rtl/mix_tree_valve_sequencer.sv
// ---------------------------------------------------------------------------
// mix_tree_valve_sequencer
//
// Sequences one dispensing run through a 32:1 mixing tree: fill selected
// inlets one at a time, enable each mixer level from the leaves to the root,
// drain the outlet, then pulse done.
//
// Optional feature macro: MIXSEQ_ABORT_EN
//   defined   -> abort=1 in FILL/MIX/DRAIN returns to IDLE on the next edge
//                without a done pulse.
//   undefined -> abort is accepted on the port but has no effect.
//
// Ports
//   clk         in   sole clock, rising edge
//   rst         in   asynchronous active-high reset
//   start       in   run request, sampled only while ready=1
//   inlet_mask  in   [31:0] inlet i is dispensed when bit i is set
//   abort       in   cancel current run (MIXSEQ_ABORT_EN only)
//   ready       out  high in IDLE only
//   valve_open  out  [31:0] inlet valve drives, at most one bit high
//   mix_en      out  [4:0] mixer level enables, bit 4 = leaves, bit 0 = root
//   out_valve   out  outlet valve drive
//   done        out  one-cycle pulse at run completion
// ---------------------------------------------------------------------------
module mix_tree_valve_sequencer #(
  parameter int FILL_CYCLES  = 4,
  parameter int MIX_CYCLES   = 8,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] inlet_mask,
  input  logic        abort,
  output logic        ready,
  output logic [31:0] valve_open,
  output logic [4:0]  mix_en,
  output logic        out_valve,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_MIX   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [7:0] FILL_LAST  = 8'(FILL_CYCLES - 1);
  localparam logic [7:0] MIX_LAST   = 8'(MIX_CYCLES - 1);
  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYCLES - 1);

  state_t      state_q, state_d;
  logic [4:0]  idx_q, idx_d;     // inlet index being visited in FILL
  logic [7:0]  cnt_q, cnt_d;     // cycles already spent in current slot
  logic [2:0]  lvl_q, lvl_d;     // mixer level, 4 = leaves down to 0 = root
  logic [31:0] mask_q, mask_d;

  logic        ready_q, ready_d;
  logic [31:0] valve_q, valve_d;
  logic [4:0]  mix_q, mix_d;
  logic        outv_q, outv_d;
  logic        done_q, done_d;

  logic        abort_hit;
  logic [7:0]  slot_last;

`ifdef MIXSEQ_ABORT_EN
  assign abort_hit = abort &&
                     ((state_q == S_FILL) || (state_q == S_MIX) || (state_q == S_DRAIN));
`else
  logic abort_unused;
  assign abort_unused = abort;
  assign abort_hit    = 1'b0;
`endif

  // A clear inlet still costs one skip cycle so the slot timing stays fixed.
  assign slot_last = mask_q[idx_q] ? FILL_LAST : 8'd0;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    lvl_d   = lvl_q;
    mask_d  = mask_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FILL;
          idx_d   = 5'd0;
          cnt_d   = 8'd0;
          mask_d  = inlet_mask;
        end
      end
      S_FILL: begin
        if (cnt_q == slot_last) begin
          cnt_d = 8'd0;
          if (idx_q == 5'd31) begin
            state_d = S_MIX;
            lvl_d   = 3'd4;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_MIX: begin
        if (cnt_q == MIX_LAST) begin
          cnt_d = 8'd0;
          if (lvl_q == 3'd0) begin
            state_d = S_DRAIN;
          end else begin
            lvl_d = lvl_q - 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          cnt_d   = 8'd0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort_hit) begin
      state_d = S_IDLE;
      idx_d   = 5'd0;
      cnt_d   = 8'd0;
      lvl_d   = 3'd0;
    end

    // Outputs are decoded from the next state so they can be registered
    // without adding a cycle of latency.
    ready_d   = (state_d == S_IDLE);
    valve_d   = ((state_d == S_FILL) && mask_d[idx_d]) ? (32'd1 << idx_d) : 32'd0;
    mix_d     = (state_d == S_MIX) ? (5'd1 << lvl_d) : 5'd0;
    outv_d    = (state_d == S_DRAIN);
    done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= 5'd0;
      cnt_q   <= 8'd0;
      lvl_q   <= 3'd0;
      mask_q  <= 32'd0;
      ready_q <= 1'b1;
      valve_q <= 32'd0;
      mix_q   <= 5'd0;
      outv_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
      mask_q  <= mask_d;
      ready_q <= ready_d;
      valve_q <= valve_d;
      mix_q   <= mix_d;
      outv_q  <= outv_d;
      done_q  <= done_d;
    end
  end

  assign ready      = ready_q;
  assign valve_open = valve_q;
  assign mix_en     = mix_q;
  assign out_valve  = outv_q;
  assign done       = done_q;

endmodule

// File: tb/tb_mix_tree_valve_sequencer.sv
// ---------------------------------------------------------------------------
// Testbench for mix_tree_valve_sequencer (default parameters).
// A per-cycle expected output trace is queued whenever a run is launched and
// a monitor compares one entry per clock after the active edge.
// ---------------------------------------------------------------------------
module tb_mix_tree_valve_sequencer;

  localparam int F = 4;
  localparam int M = 8;
  localparam int D = 4;

  typedef struct packed {
    logic        rdy;
    logic [31:0] v;
    logic [4:0]  m;
    logic        o;
    logic        d;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] inlet_mask;
  logic        abort;
  logic        ready;
  logic [31:0] valve_open;
  logic [4:0]  mix_en;
  logic        out_valve;
  logic        done;

  exp_t sb[$];
  bit   sb_en;
  int   errors;
  int   checks;
  int   trace_cyc;

  always #5 clk = ~clk;

  mix_tree_valve_sequencer #(
    .FILL_CYCLES (F),
    .MIX_CYCLES  (M),
    .DRAIN_CYCLES(D)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .inlet_mask(inlet_mask),
    .abort     (abort),
    .ready     (ready),
    .valve_open(valve_open),
    .mix_en    (mix_en),
    .out_valve (out_valve),
    .done      (done)
  );

  // Expected trace of one run, starting with the cycle after the accept
  // edge and ending with the idle cycle that follows done.
  task automatic push_run(input logic [31:0] m);
    exp_t e;
    for (int i = 0; i < 32; i++) begin
      if (m[i]) begin
        for (int k = 0; k < F; k++) begin
          e = '0; e.v = 32'd1 << i; sb.push_back(e);
        end
      end else begin
        e = '0; sb.push_back(e);
      end
    end
    for (int l = 4; l >= 0; l--) begin
      for (int k = 0; k < M; k++) begin
        e = '0; e.m = 5'd1 << l; sb.push_back(e);
      end
    end
    for (int k = 0; k < D; k++) begin
      e = '0; e.o = 1'b1; sb.push_back(e);
    end
    e = '0; e.d = 1'b1; sb.push_back(e);
    e = '0; e.rdy = 1'b1; sb.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    exp_t obs;
    forever begin
      @(posedge clk);
      #1;
      if (sb_en && sb.size() > 0) begin
        e   = sb.pop_front();
        obs = {ready, valve_open, mix_en, out_valve, done};
        trace_cyc++;
        checks++;
        if (obs !== e) begin
          errors++;
          $display("FAIL trace cyc=%0d got rdy=%b v=%h m=%b o=%b d=%b exp rdy=%b v=%h m=%b o=%b d=%b",
                   trace_cyc, obs.rdy, obs.v, obs.m, obs.o, obs.d, e.rdy, e.v, e.m, e.o, e.d);
        end
      end
    end
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #2;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; inlet_mask = 32'd0;
    #1;
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready); end
    checks++;
    if (valve_open !== 32'd0) begin errors++; $display("FAIL reset_valve got=%h exp=0", valve_open); end
    checks++;
    if ({mix_en, out_valve, done} !== 7'd0) begin
      errors++; $display("FAIL reset_misc got=%b exp=0", {mix_en, out_valve, done});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ready, valve_open, mix_en, out_valve, done} !== {1'b1, 39'd0}) begin
      errors++; $display("FAIL idle_after_reset got=%h exp=%h",
                         {ready, valve_open, mix_en, out_valve, done}, {1'b1, 39'd0});
    end
  endtask

  task automatic test_all_inlets();
    int done_cyc = 0;
    bit ok;
    @(negedge clk);
    inlet_mask = 32'hFFFF_FFFF;
    start = 1'b1;
    push_run(32'hFFFF_FFFF);
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(posedge clk);
      #2;
      if (cyc == 1) begin
        start = 1'b0;
        inlet_mask = $urandom;
      end
      if (done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
    end
    checks++;
    if (done_cyc !== 173) begin errors++; $display("FAIL all_latency got=%0d exp=173", done_cyc); end
    wait_drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL all_drain got=%0d pending exp=0", sb.size()); end
  endtask

  task automatic test_single_inlet();
    int first = 0;
    int len = 0;
    int done_cyc = 0;
    bit ok;
    @(negedge clk);
    inlet_mask = 32'h0000_0020;
    start = 1'b1;
    push_run(32'h0000_0020);
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(posedge clk);
      #2;
      if (cyc == 1) start = 1'b0;
      if (valve_open === 32'h0000_0020) begin
        if (first == 0) first = cyc;
        len++;
      end
      if (done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
    end
    checks++;
    if (first !== 6) begin errors++; $display("FAIL single_first got=%0d exp=6", first); end
    checks++;
    if (len !== F) begin errors++; $display("FAIL single_len got=%0d exp=%0d", len, F); end
    checks++;
    if (done_cyc !== 80) begin errors++; $display("FAIL single_latency got=%0d exp=80", done_cyc); end
    wait_drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_drain got=%0d pending exp=0", sb.size()); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] m1;
    logic [31:0] m2;
    bit seen_done = 1'b0;
    bit seen_ready = 1'b0;
    bit released = 1'b0;
    bit ok;
    int bad = 0;
    m1 = $urandom;
    m2 = 32'h0000_0000;
    @(negedge clk);
    inlet_mask = m1;
    start = 1'b1;
    push_run(m1);
    push_run(m2);
    for (int cyc = 1; cyc <= 1000; cyc++) begin
      @(posedge clk);
      #2;
      if (cyc == 1) inlet_mask = m2;
      if (seen_ready && ready === 1'b0) begin
        start = 1'b0;
        released = 1'b1;
        break;
      end
      if (seen_done && ready === 1'b1) seen_ready = 1'b1;
      if (done === 1'b1) seen_done = 1'b1;
    end
    checks++;
    if (!released) begin errors++; $display("FAIL b2b_second_accept got=0 exp=1"); end
    start = 1'b0;
    wait_drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_drain got=%0d pending exp=0", sb.size()); end
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #2;
      if (ready !== 1'b1 || done !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL b2b_extra_run got=%0d bad cycles exp=0", bad); end
  endtask

  task automatic test_reset_mid_mix();
    bit found = 1'b0;
    int bad = 0;
    @(negedge clk);
    inlet_mask = 32'h0;
    start = 1'b1;
    push_run(32'h0);
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(posedge clk);
      #2;
      if (cyc == 1) start = 1'b0;
      if (mix_en === 5'b00100) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL midmix_reach got=%b exp=00100", mix_en); end
    sb_en = 1'b0;
    sb.delete();
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({ready, valve_open, mix_en, out_valve, done} !== {1'b1, 39'd0}) begin
      errors++; $display("FAIL midmix_async got=%h exp=%h",
                         {ready, valve_open, mix_en, out_valve, done}, {1'b1, 39'd0});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk);
      #2;
      if (done !== 1'b0 || ready !== 1'b1 || mix_en !== 5'd0) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL midmix_no_done got=%0d bad cycles exp=0", bad); end
    sb_en = 1'b1;
  endtask

  task automatic test_abort();
    bit found = 1'b0;
    bit ok;
    @(negedge clk);
    inlet_mask = 32'h0000_00FF;
    start = 1'b1;
    push_run(32'h0000_00FF);
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(posedge clk);
      #2;
      if (cyc == 1) start = 1'b0;
      if (valve_open === 32'h0000_0080) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL abort_reach got=%h exp=00000080", valve_open); end
`ifdef MIXSEQ_ABORT_EN
    begin
      int bad = 0;
      sb_en = 1'b0;
      sb.delete();
      @(negedge clk);
      abort = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if ({ready, valve_open, mix_en, out_valve, done} !== {1'b1, 39'd0}) begin
        errors++; $display("FAIL abort_idle got=%h exp=%h",
                           {ready, valve_open, mix_en, out_valve, done}, {1'b1, 39'd0});
      end
      @(negedge clk);
      abort = 1'b0;
      for (int c = 0; c < 20; c++) begin
        @(posedge clk);
        #2;
        if (done !== 1'b0 || ready !== 1'b1) bad++;
      end
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL abort_no_done got=%0d bad cycles exp=0", bad); end
      sb_en = 1'b1;
      @(negedge clk);
      inlet_mask = 32'h8000_0001;
      start = 1'b1;
      abort = 1'b1;
      push_run(32'h8000_0001);
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
    end
`else
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
`endif
    wait_drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL abort_drain got=%0d pending exp=0", sb.size()); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    trace_cyc = 0;
    sb_en = 1'b1;
    test_reset();
    fork
      monitor();
    join_none
    test_all_inlets();
    test_single_inlet();
    test_back_to_back();
    test_reset_mid_mix();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
